// File: rtl/lap_memory_pkg.sv
// Shared constants for the lap memory.
package lap_memory_pkg;

  localparam int unsigned LAP_DEPTH = 8;   // laps kept in the ring buffer
  localparam int unsigned TIME_W    = 12;  // stopwatch time value width
  localparam int unsigned PTR_W     = 3;   // ring pointer / browse index width
  localparam int unsigned CNT_W     = 4;   // stored-lap count width, 0..LAP_DEPTH

endpackage : lap_memory_pkg

// File: rtl/lap_memory.sv
// Lap memory: 8-entry ring buffer of stopwatch times with a browse position.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   write      pulse: store wr_data as the newest lap (overwrites oldest when full)
//   read       pulse: advance browse position to the next stored lap, wrapping
//   clear      pulse: discard all stored laps
//   wr_data    time value to store
//   rd_data    registered lap at the browse position (0 while nothing is stored)
//   lap_index  browse position, 0 = oldest stored lap
//   count      number of stored laps, 0..8
//   full       count == 8
//   empty      count == 0
module lap_memory
  import lap_memory_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              write,
  input  logic              read,
  input  logic              clear,
  input  logic [TIME_W-1:0] wr_data,
  output logic [TIME_W-1:0] rd_data,
  output logic [PTR_W-1:0]  lap_index,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [TIME_W-1:0] mem [LAP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_addr;

  // Physical address of the browsed lap: oldest entry plus browse offset.
  // With count==8 the low count bits are 0, so the oldest entry is wr_ptr itself.
  always_comb begin
    rd_addr = wr_ptr - count[PTR_W-1:0] + lap_index;
  end

  // Storage, pointers, status flags and the read register.
  // The memory array is not reset; unwritten entries are masked by count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      count     <= '0;
      lap_index <= '0;
      rd_data   <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      // rd_data follows the browse position one cycle later.
      rd_data <= (count == '0) ? '0 : mem[rd_addr];

      if (clear) begin
        wr_ptr    <= '0;
        count     <= '0;
        lap_index <= '0;
        rd_data   <= '0;
        full      <= 1'b0;
        empty     <= 1'b1;
      end else if (write) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
        empty       <= 1'b0;
        if (full) begin
          lap_index <= PTR_W'(LAP_DEPTH - 1);
        end else begin
          count     <= count + CNT_W'(1);
          lap_index <= count[PTR_W-1:0];
          full      <= (count == CNT_W'(LAP_DEPTH - 1));
        end
      end else if (read && !empty) begin
        lap_index <= ({1'b0, lap_index} == count - CNT_W'(1)) ? '0
                                                              : lap_index + PTR_W'(1);
      end
    end
  end

endmodule : lap_memory

// File: tb/tb_lap_memory.sv
// Self-checking bench for lap_memory: directed scenarios plus randomized pulses
// checked against a queue-based model of the stored laps.
module tb_lap_memory;
  import lap_memory_pkg::*;

  logic              clk = 1'b0;
  logic              rst, write, read, clear;
  logic [TIME_W-1:0] wr_data;
  logic [TIME_W-1:0] rd_data;
  logic [PTR_W-1:0]  lap_index;
  logic [CNT_W-1:0]  count;
  logic              full, empty;

  int checks = 0;
  int errors = 0;

  // Reference model: laps oldest-first, browse index, expected rd_data.
  int q[$];
  int idx    = 0;
  int exp_rd = 0;

  lap_memory dut (
    .clk       (clk),
    .rst       (rst),
    .write     (write),
    .read      (read),
    .clear     (clear),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .lap_index (lap_index),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  // One clock with the given pulses; advance the model and compare all outputs.
  task automatic step(input bit rs, input bit c, input bit w, input bit r,
                      input int data);
    rst = rs; clear = c; write = w; read = r; wr_data = TIME_W'(data);
    @(posedge clk);
    #1;
    // rd_data reflects the lap browsed before this edge, unless cleared now.
    if (rs || c)          exp_rd = 0;
    else if (q.size() == 0) exp_rd = 0;
    else                  exp_rd = q[idx];
    if (rs || c) begin
      q.delete();
      idx = 0;
    end else if (w) begin
      q.push_back(data & 12'hFFF);
      if (q.size() > LAP_DEPTH) void'(q.pop_front());
      idx = q.size() - 1;
    end else if (r && q.size() > 0) begin
      idx = (idx + 1) % q.size();
    end
    check("count",     int'(count),     q.size());
    check("lap_index", int'(lap_index), idx);
    check("full",      int'(full),      int'(q.size() == LAP_DEPTH));
    check("empty",     int'(empty),     int'(q.size() == 0));
    check("rd_data",   int'(rd_data),   exp_rd);
    rst = 0; clear = 0; write = 0; read = 0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; clear = 0; write = 0; read = 0; wr_data = '0;

    // Reset state and three writes
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 12'h015);
    step(0, 0, 1, 0, 12'h020);
    step(0, 0, 1, 0, 12'h031);
    idle();
    check("w3_count", int'(count), 3);
    check("w3_idx",   int'(lap_index), 2);
    check("w3_rd",    int'(rd_data), 12'h031);

    // Three reads wrap through 0,1,2
    step(0, 0, 0, 1, 0); idle(); check("r1_rd", int'(rd_data), 12'h015);
    step(0, 0, 0, 1, 0); idle(); check("r2_rd", int'(rd_data), 12'h020);
    step(0, 0, 0, 1, 0); idle(); check("r3_rd", int'(rd_data), 12'h031);
    check("r3_idx", int'(lap_index), 2);

    // Ten writes: oldest two overwritten
    step(0, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) step(0, 0, 1, 0, i);
    check("w10_full", int'(full), 1);
    step(0, 0, 0, 1, 0);
    idle();
    check("w10_idx", int'(lap_index), 0);
    check("w10_rd",  int'(rd_data), 3);

    // Read at empty after reset
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    check("empty_rd_idx", int'(lap_index), 0);
    check("empty_rd_rd",  int'(rd_data), 0);

    // Write+read coincident, then clear+write coincident
    step(0, 0, 1, 0, 12'h0AA);
    step(0, 0, 1, 0, 12'h0BB);
    step(0, 0, 1, 1, 12'h0CC);
    check("wr_prio_count", int'(count), 3);
    check("wr_prio_idx",   int'(lap_index), 2);
    step(0, 1, 1, 0, 12'h0DD);
    check("clr_prio_empty", int'(empty), 1);

    // Reset mid-sequence overrides a coincident write
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 12'h200 + i);
    step(1, 0, 1, 1, 12'h3FF);
    check("rst_count", int'(count), 0);
    step(0, 0, 1, 0, 12'h100);
    idle();
    check("rst_w_count", int'(count), 1);
    check("rst_w_rd",    int'(rd_data), 12'h100);

    // Randomized pulses, including held pulses
    for (int n = 0; n < 3000; n++) begin
      automatic int sel = $urandom_range(0, 99);
      step(sel == 0, sel >= 1 && sel < 4, sel >= 4 && sel < 40,
           (sel >= 30 && sel < 80), int'($urandom_range(0, 4095)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_lap_memory
